lane_checker: RTL

LANE_CHECKER -- requirements
Module: lane_checker

---
 rtl/lane_chk_pkg.sv | 25 ++
 rtl/lane_chk_delay.sv | 45 ++++
 rtl/lane_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lane_chk_pkg.sv
// Shared types and helpers for the lane checker: FSM states, lane-function
// selectors and a lowest-set-bit finder used to report the first failing lane.
package lane_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam int FT_INV = 0;
  localparam int FT_BUF = 1;

  // Scanning from the top down lets the last hit win, leaving the lowest index.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/lane_chk_delay.sv
// LAT-stage valid-plus-data shift register; only the valid bits carry reset,
// so the data path can be built from plain flops.
module lane_chk_delay #(
  parameter int W   = 2,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_any_valid
);

  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_data [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_clear) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_valid;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Data is qualified by the valid bits, so it never needs a reset value.
  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < LAT; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid     = r_vld[LAT-1];
  assign o_data      = r_data[LAT-1];
  assign o_any_valid = |r_vld;

endmodule

// File: rtl/lane_checker.sv
// Compares responses from a lane array against the stimulus delayed by LAT
// cycles, keeping sticky per-lane errors, saturating counters and a small FSM.
module lane_checker
  import lane_chk_pkg::*;
#(
  parameter int FOO_START = 0,
  parameter int FOO_NUM   = 2,
  parameter int FOO_TYPE  = 0,
  parameter int LAT       = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FOO_NUM-1:0] foo,
  input  logic [FOO_NUM-1:0] bar,
  input  logic               clear,
  output logic               mismatch,
  output logic [FOO_NUM-1:0] err_lanes,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   sample_count,
  output logic [4:0]         first_err_lane,
  output logic [1:0]         state
);

  logic               w_vld_d;
  logic [FOO_NUM-1:0] w_foo_d;
  logic               w_any_vld;
  logic [FOO_NUM-1:0] w_diff;
  logic               w_cmp;
  logic               w_err;
  logic [31:0]        w_diff_ext;
  state_t             w_state_nxt;

  state_t             r_state;
  logic               r_mismatch;
  logic [FOO_NUM-1:0] r_err_lanes;
  logic [CNT_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   r_sample_count;
  logic [4:0]         r_first_err;

  lane_chk_delay #(
    .W   (FOO_NUM),
    .LAT (LAT)
  ) u_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear),
    .i_valid     (in_valid),
    .i_data      (foo),
    .o_valid     (w_vld_d),
    .o_data      (w_foo_d),
    .o_any_valid (w_any_vld)
  );

  for (genvar g = FOO_START; g < FOO_START + FOO_NUM; g++) begin : g_lane
    localparam int L = g - FOO_START;
    if (FOO_TYPE == FT_BUF) begin : g_buf
      assign w_diff[L] = bar[L] ^ w_foo_d[L];
    end else begin : g_inv
      assign w_diff[L] = bar[L] ^ ~w_foo_d[L];
    end
  end

  assign w_cmp      = w_vld_d;
  assign w_err      = w_cmp & (|w_diff);
  assign w_diff_ext = 32'(w_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ERR only exits through clear; clear overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (in_valid) w_state_nxt = FILL;
      FILL:  if (w_cmp) w_state_nxt = w_err ? ERR : CHECK;
      CHECK: begin
        if (w_err) begin
          w_state_nxt = ERR;
        end else if (!w_any_vld && !in_valid) begin
          w_state_nxt = IDLE;
        end
      end
      ERR:   w_state_nxt = ERR;
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // An empty sticky mask means no error has been seen since reset or clear,
  // which is exactly when the first failing lane should be captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch     <= 1'b0;
      r_err_lanes    <= '0;
      r_err_count    <= '0;
      r_sample_count <= '0;
      r_first_err    <= '0;
    end else if (clear) begin
      r_mismatch     <= 1'b0;
      r_err_lanes    <= '0;
      r_err_count    <= '0;
      r_sample_count <= '0;
      r_first_err    <= '0;
    end else begin
      r_mismatch <= w_err;
      if (w_cmp) begin
        r_err_lanes <= r_err_lanes | w_diff;
        if (!(&r_sample_count)) r_sample_count <= r_sample_count + 1'b1;
        if (w_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
        if (w_err && (r_err_lanes == '0)) r_first_err <= lowest_set(w_diff_ext);
      end
    end
  end

  assign mismatch       = r_mismatch;
  assign err_lanes      = r_err_lanes;
  assign err_count      = r_err_count;
  assign sample_count   = r_sample_count;
  assign first_err_lane = r_first_err;
  assign state          = r_state;

endmodule
